lc3_control: RTL and testbench
==============================

Name: lc3_control

Overview:
- Multi-cycle control FSM for the LC-3 datapath.
- Fetches, decodes and executes one instruction at a time by driving the datapath's mux selects, load enables, bus tri-state enables and register-file addresses.
- Sequences a variable-latency memory port through a request/ready handshake.
- Sits beside the datapath; it sees only IR, the nzp flags and memory ready.

Parameters:
MAX_WAIT, 16, memory cycles allowed per access before timeout; 0 disables the timeout.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
IR  input  16  instruction register from datapath
nzp  input  3  {N,Z,P} condition flags
memRdy  input  1  memory completes current access this cycle
selEAB1  output  1  0 = PC, 1 = SR1_out
selEAB2  output  2  00 = 0, 01 = sext IR[5:0], 10 = sext IR[8:0], 11 = sext IR[10:0]
selPC  output  2  00 = PC+1, 01 = eab_out, 10 = bus
selMAR  output  1  0 = eab_out, 1 = zext IR[7:0]
selMDR  output  1  0 = bus, 1 = memory data
aluControl  output  2  00 PASS SR1, 01 ADD, 10 AND, 11 NOT
enaALU, enaMARM, enaPC, enaMDR  output  1 each  bus tri-state enables
ldPC, ldIR, ldMAR, ldMDR, regWE, flagWE  output  1 each  load strobes
SR1, SR2, DR  output  3 each  register-file addresses
memEN  output  1  memory request
memWE  output  1  memory write; valid only with memEN
instrDone  output  1  one-cycle pulse on the last cycle of each instruction
illegalOp  output  1  one-cycle pulse on an unsupported opcode
memTimeout  output  1  sticky; cleared only by reset

Behaviour:
- States: FETCH0, FETCH1, FETCH2, DECODE, EXEC, BR, JMP, ADDR, MEMRD, WB, LDMDR, MEMWR, HALT.
- All outputs are Moore, decoded from state and IR, except:
  - ldMDR in MEMRD/FETCH1 is gated by memRdy.
  - The BR ldPC is gated by the nzp match.
- Invariant in every state and cycle:
  - At most one of enaALU, enaMARM, enaPC, enaMDR is high.
  - Any strobe not listed for a state is 0; selects not listed are 0.
- Reset (asynchronous, rst = 0):
  - State goes to FETCH0.
  - Every output drops to 0 immediately, including memEN mid-access.
  - memTimeout and the wait counter clear.
- FETCH0: enaPC, ldMAR, ldPC, selPC = 00 → FETCH1.
- FETCH1: memEN, selMDR = 1.
  - On memRdy: ldMDR, then → FETCH2.
  - Otherwise stay in FETCH1.
- FETCH2: enaMDR, ldIR → DECODE.
- DECODE: no strobes. Next state by IR[15:12]:
  - ADD (0001), AND (0101), NOT (1001), LEA (1110) → EXEC.
  - BR (0000) → BR.
  - JMP (1100) → JMP.
  - LD (0010), LDR (0110), ST (0011), STR (0111) → ADDR.
  - Any other opcode → FETCH0 with illegalOp and instrDone pulsed.
- EXEC: DR = IR[11:9], regWE, flagWE, instrDone → FETCH0.
  - ALU ops: SR1 = IR[8:6], SR2 = IR[2:0], enaALU, aluControl = ADD/AND/NOT.
  - LEA: selEAB1 = 0, selEAB2 = 10, selMAR = 0, enaMARM.
- BR: selEAB1 = 0, selEAB2 = 10, selPC = 01.
  - ldPC only if (IR[11:9] & nzp) != 0.
  - instrDone in either case → FETCH0.
- JMP: SR1 = IR[8:6], selEAB1 = 1, selEAB2 = 00, selPC = 01, ldPC, instrDone → FETCH0.
- ADDR: selMAR = 0, enaMARM, ldMAR.
  - LD/ST: selEAB1 = 0, selEAB2 = 10.
  - LDR/STR: selEAB1 = 1, SR1 = IR[8:6], selEAB2 = 01.
  - Loads → MEMRD; stores → LDMDR.
- MEMRD: memEN, selMDR = 1.
  - On memRdy: ldMDR → WB.
  - Otherwise stay in MEMRD.
- WB: enaMDR, DR = IR[11:9], regWE, flagWE, instrDone → FETCH0.
- LDMDR: SR1 = IR[11:9], aluControl = 00, enaALU, selMDR = 0, ldMDR → MEMWR.
- MEMWR: memEN, memWE. On memRdy: instrDone → FETCH0.
- Memory handshake:
  - memEN holds high from state entry until the cycle memRdy is sampled high.
  - memRdy while memEN = 0 is ignored.
  - memRdy in the entry cycle gives a one-cycle access.
- Wait counter (MAX_WAIT > 0):
  - Increments each cycle in FETCH1, MEMRD or MEMWR without memRdy; clears on state exit.
  - Reaching MAX_WAIT sets memTimeout and moves to HALT.
- HALT: all strobes 0; stays in HALT until reset.
- Minimum latencies (memRdy immediate):
  - ALU op, LEA, BR, JMP: 5 cycles.
  - LD/LDR: 7 cycles.
  - ST/STR: 7 cycles.

Test Plan:
- ADD R3, R1, R2 (IR = 0x1642), memRdy always 1 → five cycles FETCH0..EXEC; in EXEC: SR1 = 1, SR2 = 2, DR = 3, aluControl = 01, enaALU, regWE, flagWE, instrDone.
- BRz #5 (IR = 0x0405) with nzp = 010 → ldPC with selPC = 01, selEAB2 = 10. Same IR with nzp = 100 → ldPC = 0, instrDone = 1.
- LDR R2, R5, #-1 (IR = 0x657F), memRdy delayed 3 cycles → memEN high 4 cycles in MEMRD, single ldMDR pulse on the memRdy cycle, WB has DR = 2, enaMDR.
- STR R4, R6, #2 (IR = 0x7982) → LDMDR drives SR1 = 4, enaALU, ldMDR; MEMWR drives memEN = memWE = 1 until memRdy.
- Opcode 1101 → DECODE → FETCH0 with illegalOp and instrDone pulsed for one cycle; no other strobes.
- MAX_WAIT = 4 and memRdy held 0 in FETCH1 → memTimeout rises after 4 cycles, state HALT. Asserting rst mid-MEMWR → memEN, memWE drop the same cycle; restart at FETCH0.

Source files
------------

// File: rtl/lc3_control.sv
// lc3_control -- multi-cycle control FSM for the LC-3 datapath.
//
// Fetches, decodes and executes one instruction at a time. It drives the
// datapath mux selects, load strobes, bus tri-state enables and register-file
// addresses, and it sequences a variable-latency memory port through a
// memEN/memRdy handshake. It sees only IR, the nzp flags and memRdy.
//
// Parameters:
//   MAX_WAIT    memory cycles allowed per access before timeout (0 = no timeout)
//
// Ports:
//   clk         system clock
//   rst         asynchronous active-low reset
//   IR          instruction register from the datapath
//   nzp         {N,Z,P} condition flags
//   memRdy      memory completes the current access this cycle
//   selEAB1     0 = PC, 1 = SR1_out
//   selEAB2     00 = 0, 01 = sext IR[5:0], 10 = sext IR[8:0], 11 = sext IR[10:0]
//   selPC       00 = PC+1, 01 = eab_out, 10 = bus
//   selMAR      0 = eab_out, 1 = zext IR[7:0]
//   selMDR      0 = bus, 1 = memory data
//   aluControl  00 PASS SR1, 01 ADD, 10 AND, 11 NOT
//   enaALU/enaMARM/enaPC/enaMDR   bus tri-state enables (at most one high)
//   ldPC/ldIR/ldMAR/ldMDR/regWE/flagWE   load strobes
//   SR1/SR2/DR  register-file addresses
//   memEN       memory request
//   memWE       memory write, valid only with memEN
//   instrDone   pulse on the last cycle of each instruction
//   illegalOp   pulse on an unsupported opcode
//   memTimeout  sticky memory timeout, cleared only by reset
//
// state  | meaning
// -------+------------------------------------------------------------
// FETCH0 | MAR <- PC, PC <- PC+1
// FETCH1 | instruction read; wait for memRdy, MDR <- memory
// FETCH2 | IR <- MDR
// DECODE | dispatch on IR[15:12]; unsupported opcodes end here
// EXEC   | ADD/AND/NOT through the ALU, LEA through MARMUX; write DR
// BR     | PC <- PC + sext(IR[8:0]) if IR[11:9] & nzp
// JMP    | PC <- SR1
// ADDR   | MAR <- effective address for LD/LDR/ST/STR
// MEMRD  | data read; wait for memRdy, MDR <- memory
// WB     | DR <- MDR
// LDMDR  | MDR <- SR (store data, passed through the ALU)
// MEMWR  | data write; wait for memRdy
// HALT   | memory timeout; frozen until reset

module lc3_control #(
  parameter int MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] IR,
  input  logic [2:0]  nzp,
  input  logic        memRdy,
  output logic        selEAB1,
  output logic [1:0]  selEAB2,
  output logic [1:0]  selPC,
  output logic        selMAR,
  output logic        selMDR,
  output logic [1:0]  aluControl,
  output logic        enaALU,
  output logic        enaMARM,
  output logic        enaPC,
  output logic        enaMDR,
  output logic        ldPC,
  output logic        ldIR,
  output logic        ldMAR,
  output logic        ldMDR,
  output logic        regWE,
  output logic        flagWE,
  output logic [2:0]  SR1,
  output logic [2:0]  SR2,
  output logic [2:0]  DR,
  output logic        memEN,
  output logic        memWE,
  output logic        instrDone,
  output logic        illegalOp,
  output logic        memTimeout
);

  typedef enum logic [3:0] {
    FETCH0, FETCH1, FETCH2, DECODE, EXEC, BR, JMP,
    ADDR, MEMRD, WB, LDMDR, MEMWR, HALT
  } state_t;

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_LEA = 4'b1110;

  localparam logic [1:0] ALU_PASS = 2'b00;
  localparam logic [1:0] ALU_ADD  = 2'b01;
  localparam logic [1:0] ALU_AND  = 2'b10;
  localparam logic [1:0] ALU_NOT  = 2'b11;

  localparam logic [1:0] EAB2_OFF6 = 2'b01;
  localparam logic [1:0] EAB2_OFF9 = 2'b10;
  localparam logic [1:0] PC_EAB    = 2'b01;

  // The counter only needs to hold 0..MAX_WAIT-1: the cycle that would bring
  // it to MAX_WAIT is the one that raises the timeout.
  localparam int CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CW-1:0] WAIT_LAST = (MAX_WAIT > 0) ? CW'(MAX_WAIT - 1) : '0;

  state_t        state_q, state_d;
  logic [CW-1:0] wait_cnt;
  logic          timeout_q;
  logic          timeout_set;
  logic          mem_wait;
  logic [3:0]    op;
  logic          is_reg_base;
  logic          is_load;

  // IR[5:3] carries no control information for the supported opcodes.
  logic          unused_ir;
  assign unused_ir = ^IR[5:3];

  assign op          = IR[15:12];
  assign is_reg_base = (op == OP_LDR) || (op == OP_STR);
  assign is_load     = (op == OP_LD)  || (op == OP_LDR);
  assign mem_wait    = (state_q == FETCH1) || (state_q == MEMRD) || (state_q == MEMWR);
  assign memTimeout  = timeout_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= FETCH0;
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (timeout_set) begin
        timeout_q <= 1'b1;
      end
      if ((MAX_WAIT > 0) && mem_wait && !memRdy && (state_d == state_q)) begin
        wait_cnt <= wait_cnt + CW'(1);
      end else begin
        wait_cnt <= '0;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    timeout_set = 1'b0;
    selEAB1     = 1'b0;
    selEAB2     = 2'b00;
    selPC       = 2'b00;
    selMAR      = 1'b0;
    selMDR      = 1'b0;
    aluControl  = ALU_PASS;
    enaALU      = 1'b0;
    enaMARM     = 1'b0;
    enaPC       = 1'b0;
    enaMDR      = 1'b0;
    ldPC        = 1'b0;
    ldIR        = 1'b0;
    ldMAR       = 1'b0;
    ldMDR       = 1'b0;
    regWE       = 1'b0;
    flagWE      = 1'b0;
    SR1         = 3'd0;
    SR2         = 3'd0;
    DR          = 3'd0;
    memEN       = 1'b0;
    memWE       = 1'b0;
    instrDone   = 1'b0;
    illegalOp   = 1'b0;

    case (state_q)
      FETCH0: begin
        enaPC   = 1'b1;
        ldMAR   = 1'b1;
        ldPC    = 1'b1;
        state_d = FETCH1;
      end
      FETCH1: begin
        memEN  = 1'b1;
        selMDR = 1'b1;
        if (memRdy) begin
          ldMDR   = 1'b1;
          state_d = FETCH2;
        end
      end
      FETCH2: begin
        enaMDR  = 1'b1;
        ldIR    = 1'b1;
        state_d = DECODE;
      end
      DECODE: begin
        case (op)
          OP_ADD, OP_AND, OP_NOT, OP_LEA: state_d = EXEC;
          OP_BR:                          state_d = BR;
          OP_JMP:                         state_d = JMP;
          OP_LD, OP_LDR, OP_ST, OP_STR:   state_d = ADDR;
          default: begin
            illegalOp = 1'b1;
            instrDone = 1'b1;
            state_d   = FETCH0;
          end
        endcase
      end
      EXEC: begin
        DR        = IR[11:9];
        regWE     = 1'b1;
        flagWE    = 1'b1;
        instrDone = 1'b1;
        state_d   = FETCH0;
        if (op == OP_LEA) begin
          selEAB2 = EAB2_OFF9;
          enaMARM = 1'b1;
        end else begin
          SR1    = IR[8:6];
          SR2    = IR[2:0];
          enaALU = 1'b1;
          case (op)
            OP_ADD:  aluControl = ALU_ADD;
            OP_AND:  aluControl = ALU_AND;
            default: aluControl = ALU_NOT;
          endcase
        end
      end
      BR: begin
        selEAB2   = EAB2_OFF9;
        selPC     = PC_EAB;
        ldPC      = |(IR[11:9] & nzp);
        instrDone = 1'b1;
        state_d   = FETCH0;
      end
      JMP: begin
        SR1       = IR[8:6];
        selEAB1   = 1'b1;
        selPC     = PC_EAB;
        ldPC      = 1'b1;
        instrDone = 1'b1;
        state_d   = FETCH0;
      end
      ADDR: begin
        enaMARM = 1'b1;
        ldMAR   = 1'b1;
        if (is_reg_base) begin
          selEAB1 = 1'b1;
          SR1     = IR[8:6];
          selEAB2 = EAB2_OFF6;
        end else begin
          selEAB2 = EAB2_OFF9;
        end
        state_d = is_load ? MEMRD : LDMDR;
      end
      MEMRD: begin
        memEN  = 1'b1;
        selMDR = 1'b1;
        if (memRdy) begin
          ldMDR   = 1'b1;
          state_d = WB;
        end
      end
      WB: begin
        enaMDR    = 1'b1;
        DR        = IR[11:9];
        regWE     = 1'b1;
        flagWE    = 1'b1;
        instrDone = 1'b1;
        state_d   = FETCH0;
      end
      LDMDR: begin
        SR1     = IR[11:9];
        enaALU  = 1'b1;
        ldMDR   = 1'b1;
        state_d = MEMWR;
      end
      MEMWR: begin
        memEN = 1'b1;
        memWE = 1'b1;
        if (memRdy) begin
          instrDone = 1'b1;
          state_d   = FETCH0;
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = FETCH0;
      end
    endcase

    if ((MAX_WAIT > 0) && mem_wait && !memRdy && (wait_cnt == WAIT_LAST)) begin
      timeout_set = 1'b1;
      state_d     = HALT;
    end

    // Reset must silence the datapath at once, even mid-access, rather than
    // showing FETCH0 decode while rst is still low.
    if (!rst) begin
      selEAB1    = 1'b0;
      selEAB2    = 2'b00;
      selPC      = 2'b00;
      selMAR     = 1'b0;
      selMDR     = 1'b0;
      aluControl = ALU_PASS;
      enaALU     = 1'b0;
      enaMARM    = 1'b0;
      enaPC      = 1'b0;
      enaMDR     = 1'b0;
      ldPC       = 1'b0;
      ldIR       = 1'b0;
      ldMAR      = 1'b0;
      ldMDR      = 1'b0;
      regWE      = 1'b0;
      flagWE     = 1'b0;
      SR1        = 3'd0;
      SR2        = 3'd0;
      DR         = 3'd0;
      memEN      = 1'b0;
      memWE      = 1'b0;
      instrDone  = 1'b0;
      illegalOp  = 1'b0;
    end
  end

endmodule

// File: tb/tb_lc3_control.sv
// Testbench for lc3_control: a memory model answers the DUT's memory
// requests, and per-cycle expected control words are queued per instruction
// and popped/compared every cycle.
module tb_lc3_control;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] IR;
  logic [2:0]  nzp;
  logic        memRdy;
  logic        selEAB1, selMAR, selMDR;
  logic [1:0]  selEAB2, selPC, aluControl;
  logic        enaALU, enaMARM, enaPC, enaMDR;
  logic        ldPC, ldIR, ldMAR, ldMDR, regWE, flagWE;
  logic [2:0]  SR1, SR2, DR;
  logic        memEN, memWE, instrDone, illegalOp, memTimeout;

  lc3_control #(.MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst), .IR(IR), .nzp(nzp), .memRdy(memRdy),
    .selEAB1(selEAB1), .selEAB2(selEAB2), .selPC(selPC), .selMAR(selMAR),
    .selMDR(selMDR), .aluControl(aluControl),
    .enaALU(enaALU), .enaMARM(enaMARM), .enaPC(enaPC), .enaMDR(enaMDR),
    .ldPC(ldPC), .ldIR(ldIR), .ldMAR(ldMAR), .ldMDR(ldMDR),
    .regWE(regWE), .flagWE(flagWE),
    .SR1(SR1), .SR2(SR2), .DR(DR),
    .memEN(memEN), .memWE(memWE), .instrDone(instrDone),
    .illegalOp(illegalOp), .memTimeout(memTimeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       selEAB1;
    logic [1:0] selEAB2;
    logic [1:0] selPC;
    logic       selMAR;
    logic       selMDR;
    logic [1:0] aluControl;
    logic       enaALU, enaMARM, enaPC, enaMDR;
    logic       ldPC, ldIR, ldMAR, ldMDR, regWE, flagWE;
    logic [2:0] SR1, SR2, DR;
    logic       memEN, memWE, instrDone, illegalOp, memTimeout;
  } outs_t;

  typedef struct {
    string tag;
    outs_t v;
  } exp_t;

  outs_t act;
  assign act = {selEAB1, selEAB2, selPC, selMAR, selMDR, aluControl,
                enaALU, enaMARM, enaPC, enaMDR,
                ldPC, ldIR, ldMAR, ldMDR, regWE, flagWE,
                SR1, SR2, DR, memEN, memWE, instrDone, illegalOp, memTimeout};

  exp_t sbq[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // memory model state
  int   mem_dly  = 0;
  int   mw       = 0;
  bit   mem_hold = 1'b0;
  bit   rdy_idle = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  task automatic push(input string tag, input outs_t v);
    exp_t e;
    e.tag = tag;
    e.v   = v;
    sbq.push_back(e);
  endtask

  // memRdy rises on the (mem_dly+1)-th cycle of a request; outside a request
  // it follows rdy_idle, which the DUT must ignore.
  task automatic drive_mem();
    if (memEN) begin
      memRdy = !mem_hold && (mw >= mem_dly);
      mw = memRdy ? 0 : mw + 1;
    end else begin
      memRdy = rdy_idle;
      mw = 0;
    end
  endtask

  // Entered and left at posedge+1; one popped entry per clock cycle.
  task automatic run_sb();
    while (sbq.size() > 0) begin
      exp_t e;
      drive_mem();
      @(negedge clk);
      e = sbq.pop_front();
      check_eq(e.tag, 64'(act), 64'(e.v));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic exp_fetch(input int d, input bit legal);
    outs_t e;
    e = '0; e.enaPC = 1; e.ldMAR = 1; e.ldPC = 1;
    push("fetch0", e);
    for (int i = 0; i < d; i++) begin
      e = '0; e.memEN = 1; e.selMDR = 1;
      push("fetch1_wait", e);
    end
    e = '0; e.memEN = 1; e.selMDR = 1; e.ldMDR = 1;
    push("fetch1_rdy", e);
    e = '0; e.enaMDR = 1; e.ldIR = 1;
    push("fetch2", e);
    e = '0;
    if (!legal) begin
      e.illegalOp = 1; e.instrDone = 1;
    end
    push("decode", e);
  endtask

  task automatic do_alu(input logic [15:0] ir, input logic [1:0] alu,
                        input logic [2:0] s1, input logic [2:0] s2, input logic [2:0] d);
    outs_t e;
    IR = ir; mem_dly = 0;
    exp_fetch(0, 1);
    e = '0; e.SR1 = s1; e.SR2 = s2; e.DR = d; e.aluControl = alu;
    e.enaALU = 1; e.regWE = 1; e.flagWE = 1; e.instrDone = 1;
    push("exec_alu", e);
    run_sb();
  endtask

  task automatic do_br(input logic [15:0] ir, input logic [2:0] flags, input bit taken);
    outs_t e;
    IR = ir; nzp = flags; mem_dly = 0;
    exp_fetch(0, 1);
    e = '0; e.selEAB2 = 2'b10; e.selPC = 2'b01; e.ldPC = taken; e.instrDone = 1;
    push(taken ? "br_taken" : "br_not_taken", e);
    run_sb();
  endtask

  task automatic do_load(input logic [15:0] ir, input int d, input bit reg_base,
                         input logic [2:0] base, input logic [2:0] dst);
    outs_t e;
    IR = ir; mem_dly = d;
    exp_fetch(d, 1);
    e = '0; e.enaMARM = 1; e.ldMAR = 1;
    e.selEAB1 = reg_base; e.SR1 = reg_base ? base : 3'd0;
    e.selEAB2 = reg_base ? 2'b01 : 2'b10;
    push("ld_addr", e);
    for (int i = 0; i < d; i++) begin
      e = '0; e.memEN = 1; e.selMDR = 1;
      push("memrd_wait", e);
    end
    e = '0; e.memEN = 1; e.selMDR = 1; e.ldMDR = 1;
    push("memrd_rdy", e);
    e = '0; e.enaMDR = 1; e.DR = dst; e.regWE = 1; e.flagWE = 1; e.instrDone = 1;
    push("wb", e);
    run_sb();
  endtask

  // Queues a store up to n_wr MEMWR cycles; finishes it when complete is set.
  task automatic push_store(input logic [15:0] ir, input int d, input bit reg_base,
                            input logic [2:0] base, input logic [2:0] src,
                            input int n_wr, input bit complete);
    outs_t e;
    IR = ir; mem_dly = d;
    exp_fetch(d, 1);
    e = '0; e.enaMARM = 1; e.ldMAR = 1;
    e.selEAB1 = reg_base; e.SR1 = reg_base ? base : 3'd0;
    e.selEAB2 = reg_base ? 2'b01 : 2'b10;
    push("st_addr", e);
    e = '0; e.SR1 = src; e.enaALU = 1; e.ldMDR = 1;
    push("ldmdr", e);
    for (int i = 0; i < n_wr; i++) begin
      e = '0; e.memEN = 1; e.memWE = 1;
      push("memwr_wait", e);
    end
    if (complete) begin
      e = '0; e.memEN = 1; e.memWE = 1; e.instrDone = 1;
      push("memwr_rdy", e);
    end
  endtask

  initial begin
    outs_t e;
    IR = 16'h0000; nzp = 3'b000; memRdy = 1'b0;

    // reset: all outputs low, even with memRdy asserted
    rst = 1'b0;
    repeat (2) @(posedge clk);
    memRdy = 1'b1;
    @(negedge clk);
    check_eq("reset_outputs", 64'(act), 64'(0));
    @(posedge clk); #1;
    rst = 1'b1; memRdy = 1'b0;

    do_alu(16'h1642, 2'b01, 3'd1, 3'd2, 3'd3);   // ADD R3,R1,R2
    do_alu(16'h5A87, 2'b10, 3'd2, 3'd7, 3'd5);   // AND R5,R2,R7
    do_alu(16'h933F, 2'b11, 3'd4, 3'd7, 3'd1);   // NOT R1,R4

    // LEA R6,#3
    IR = 16'hEC03; mem_dly = 0;
    exp_fetch(0, 1);
    e = '0; e.DR = 3'd6; e.regWE = 1; e.flagWE = 1; e.instrDone = 1;
    e.selEAB2 = 2'b10; e.enaMARM = 1;
    push("exec_lea", e);
    run_sb();

    do_br(16'h0405, 3'b010, 1'b1);               // BRz, Z set
    do_br(16'h0405, 3'b100, 1'b0);               // BRz, N set
    do_br(16'h0E05, 3'b001, 1'b1);               // BRnzp

    // JMP R3
    IR = 16'hC0C0; mem_dly = 0;
    exp_fetch(0, 1);
    e = '0; e.SR1 = 3'd3; e.selEAB1 = 1; e.selPC = 2'b01; e.ldPC = 1; e.instrDone = 1;
    push("jmp", e);
    run_sb();

    do_load(16'h657F, 3, 1'b1, 3'd5, 3'd2);      // LDR R2,R5,#-1, 3 wait cycles
    do_load(16'h2204, 1, 1'b0, 3'd0, 3'd1);      // LD R1,#4

    push_store(16'h7982, 2, 1'b1, 3'd6, 3'd4, 2, 1'b1);  // STR R4,R6,#2
    run_sb();
    push_store(16'h3A05, 0, 1'b0, 3'd0, 3'd5, 0, 1'b1);  // ST R5,#5
    run_sb();

    // unsupported opcodes, with memRdy high whenever no request is open
    rdy_idle = 1'b1;
    IR = 16'hD000; mem_dly = 1;
    exp_fetch(1, 0);
    run_sb();
    IR = 16'hF025; mem_dly = 0;
    exp_fetch(0, 0);
    run_sb();
    rdy_idle = 1'b0;

    // reset in the middle of a write drops memEN/memWE at once
    push_store(16'h7982, 3, 1'b1, 3'd6, 3'd4, 2, 1'b0);
    run_sb();
    rst = 1'b0; memRdy = 1'b0;
    #1;
    check_eq("rst_mid_memwr", 64'(act), 64'(0));
    @(posedge clk); #1;
    rst = 1'b1;
    do_alu(16'h1642, 2'b01, 3'd1, 3'd2, 3'd3);   // restarts at FETCH0

    // memory never answers: timeout after 4 waiting cycles, then HALT
    mem_hold = 1'b1;
    exp_fetch(3, 1);
    void'(sbq.pop_back());   // decode
    void'(sbq.pop_back());   // fetch2
    void'(sbq.pop_back());   // fetch1_rdy
    e = '0; e.memEN = 1; e.selMDR = 1;
    push("fetch1_last_wait", e);
    for (int i = 0; i < 3; i++) begin
      e = '0; e.memTimeout = 1;
      push("halt", e);
    end
    run_sb();
    rst = 1'b0;
    #1;
    check_eq("timeout_cleared", 64'(act), 64'(0));
    @(posedge clk); #1;
    rst = 1'b1; mem_hold = 1'b0;
    do_alu(16'h1642, 2'b01, 3'd1, 3'd2, 3'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
